// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory answering the M-stage access.
// Requests arrive on a valid/ready handshake; a registered one-cycle response
// follows LATENCY edges after the accepting edge. busy freezes the pipeline
// while an access is outstanding.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 2;          // byte address bits that matter
  localparam int CNT_W = $clog2(LATENCY) + 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Control
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;
  logic             w_enter_resp;
  logic             r_busy;

  // Request latched at accept
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_sign;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;

  // Operation committed on the edge that enters RESP
  logic                  w_op_we;
  logic [1:0]            w_op_size;
  logic                  w_op_sign;
  logic [AW-1:0]         w_op_addr;
  logic [31:0]           w_op_wdata;
  logic                  w_op_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [3:0]            w_be;
  logic [31:0]           w_wlanes;

  // Read word and the attributes needed to format it
  logic [31:0] w_rd_word;
  logic        r_rsp_we;
  logic        r_rsp_sign;
  logic        r_rsp_err;
  logic [1:0]  r_rsp_size;
  logic [1:0]  r_rsp_lane;
  logic [7:0]  w_sel_byte;
  logic [15:0] w_sel_half;
  logic [31:0] w_load_data;

  // Registered response
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  // Upper address bits alias away by design
  logic w_unused_addr;
  assign w_unused_addr = ^req_addr[31:AW];

  // Ready is withheld while waiting and while reset is held
  assign req_ready = ~rst & (r_state != S_WAIT);
  assign w_accept  = req_valid & req_ready;

  // Next-state and latency counter
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = CNT_W'(LATENCY - 2);
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, counter and busy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  // Capture the request on the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_sign  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_sign  <= req_sign;
      r_addr  <= req_addr[AW-1:0];
      r_wdata <= req_wdata;
    end
  end

  // With LATENCY 1 the accepting edge is also the edge entering RESP, so the
  // array operation must come straight from the request inputs.
  generate
    if (LATENCY == 1) begin : g_op_direct
      assign w_op_we    = req_we;
      assign w_op_size  = req_size;
      assign w_op_sign  = req_sign;
      assign w_op_addr  = req_addr[AW-1:0];
      assign w_op_wdata = req_wdata;
    end else begin : g_op_latched
      assign w_op_we    = r_we;
      assign w_op_size  = r_size;
      assign w_op_sign  = r_sign;
      assign w_op_addr  = r_addr;
      assign w_op_wdata = r_wdata;
    end
  endgenerate

  assign w_enter_resp = ~rst & (w_state_next == S_RESP);
  assign w_idx        = w_op_addr[AW-1:2];

  // Alignment check, lane enables and lane-replicated store data
  always_comb begin
    w_op_err = 1'b0;
    w_be     = 4'b0000;
    w_wlanes = w_op_wdata;
    case (w_op_size)
      SZ_BYTE: begin
        w_be     = 4'b0001 << w_op_addr[1:0];
        w_wlanes = {4{w_op_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_op_err = w_op_addr[0];
        w_be     = w_op_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_op_wdata[15:0]}};
      end
      SZ_WORD: begin
        w_op_err = (w_op_addr[1:0] != 2'b00);
        w_be     = 4'b1111;
      end
      default: w_op_err = 1'b1;
    endcase
    if (w_op_err || !w_op_we) begin
      w_be = 4'b0000;
    end
  end

  // One byte-wide array per lane so partial stores leave other lanes intact
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane_mem [0:DEPTH-1];
      logic [7:0] r_rd_lane;

      // Lane write and registered lane read on the edge entering RESP
      always_ff @(posedge clk) begin
        if (w_enter_resp) begin
          if (w_be[gi]) begin
            r_lane_mem[w_idx] <= w_wlanes[gi*8 +: 8];
          end
          r_rd_lane <= r_lane_mem[w_idx];
        end
      end

      assign w_rd_word[gi*8 +: 8] = r_rd_lane;
    end
  endgenerate

  // Remember how to format the word read alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_we   <= 1'b0;
      r_rsp_sign <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_rsp_size <= 2'b00;
      r_rsp_lane <= 2'b00;
    end else if (w_enter_resp) begin
      r_rsp_we   <= w_op_we;
      r_rsp_sign <= w_op_sign;
      r_rsp_err  <= w_op_err;
      r_rsp_size <= w_op_size;
      r_rsp_lane <= w_op_addr[1:0];
    end
  end

  // Lane extraction and sign/zero extension of load data
  always_comb begin
    case (r_rsp_lane)
      2'd0:    w_sel_byte = w_rd_word[7:0];
      2'd1:    w_sel_byte = w_rd_word[15:8];
      2'd2:    w_sel_byte = w_rd_word[23:16];
      default: w_sel_byte = w_rd_word[31:24];
    endcase
    w_sel_half  = r_rsp_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    w_load_data = w_rd_word;
    case (r_rsp_size)
      SZ_BYTE: w_load_data = {{24{r_rsp_sign & w_sel_byte[7]}}, w_sel_byte};
      SZ_HALF: w_load_data = {{16{r_rsp_sign & w_sel_half[15]}}, w_sel_half};
      default: w_load_data = w_rd_word;
    endcase
  end

  // Response registers: pulse out of RESP, zero everywhere else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else if (r_state == S_RESP) begin
      r_resp_valid <= 1'b1;
      r_resp_err   <= r_rsp_err;
      r_resp_rdata <= (r_rsp_we || r_rsp_err) ? 32'h0 : w_load_data;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with one instance at
// LATENCY 2 and one at LATENCY 1 sharing clock, reset and request fields.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v1 = 1'b0;
  logic        v2 = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sgn = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rdy1, rdy2, rv1, rv2, err1, err2, busy1, busy2;
  logic [31:0] rd1, rd2;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   vec_id = 0;
  exp_t sb1[$];
  exp_t sb2[$];
  exp_t got1[$];
  exp_t got2[$];

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_we(we),
    .req_size(size), .req_sign(sgn), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv2), .resp_rdata(rd2), .resp_err(err2), .busy(busy2)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we),
    .req_size(size), .req_sign(sgn), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every response pulse with the edge count that raised it
  always @(negedge clk) begin : mon
    exp_t g;
    g.id = 0;
    g.cyc = cyc;
    if (rv2 === 1'b1) begin
      g.rdata = rd2;
      g.err   = err2;
      got2.push_back(g);
    end
    if (rv1 === 1'b1) begin
      g.rdata = rd1;
      g.err   = err1;
      got1.push_back(g);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  // Drive a request, wait for its accepting edge, and push the expected result
  task automatic issue(input int d, input logic i_we, input logic [1:0] i_size,
                       input logic i_sgn, input logic [31:0] i_addr, input logic [31:0] i_wdata,
                       input logic [31:0] x_rdata, input logic x_err);
    int   t = 0;
    exp_t e;
    @(negedge clk);
    we = i_we; size = i_size; sgn = i_sgn; addr = i_addr; wdata = i_wdata;
    if (d == 1) v1 = 1'b1; else v2 = 1'b1;
    while (t < 50 && ((d == 1) ? rdy1 : rdy2) !== 1'b1) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    vec_id++;
    e.rdata = x_rdata; e.err = x_err; e.cyc = cyc; e.id = vec_id;
    if (d == 1) sb1.push_back(e); else sb2.push_back(e);
  endtask

  // Drop valid and wait (bounded) until every expected response has arrived
  task automatic wait_drain(input int d);
    int t = 0;
    @(negedge clk);
    v1 = 1'b0;
    v2 = 1'b0;
    while (t < 40 && ((d == 1) ? (got1.size() < sb1.size()) : (got2.size() < sb2.size()))) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; v1 = 1'b0; v2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (rdy2 !== 1'b0 || rdy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got rdy2=%b rdy1=%b, required 0 0", rdy2, rdy1);
    end
    n_vec++;
    if (rv2 !== 1'b0 || rd2 !== 32'h0 || err2 !== 1'b0 || busy2 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_l2: got v=%b rd=%08h err=%b busy=%b, required 0 0 0 0", rv2, rd2, err2, busy2);
    end
    n_vec++;
    if (rv1 !== 1'b0 || rd1 !== 32'h0 || err1 !== 1'b0 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_l1: got v=%b rd=%08h err=%b busy=%b, required 0 0 0 0", rv1, rd1, err1, busy1);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rdy2 !== 1'b1 || rdy1 !== 1'b1 || busy2 !== 1'b0 || rv2 !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got rdy2=%b rdy1=%b busy2=%b v2=%b, required 1 1 0 0", rdy2, rdy1, busy2, rv2);
    end
    $display("reset: done");
  endtask

  task automatic test_store_load();
    exp_t e;
    exp_t g;
    int   prev = -1;
    issue(2, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    n_vec++;
    if (busy2 !== 1'b1 || rdy2 !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_state: got busy=%b ready=%b, required 1 0", busy2, rdy2);
    end
    issue(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(2, 1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF5A, 32'h0, 1'b0);
    issue(2, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h5AADBEEF, 1'b0);
    issue(2, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000005A, 1'b0);
    issue(2, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    issue(2, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    issue(2, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0);
    issue(2, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00005AAD, 1'b0);
    wait_drain(2);
    while (sb2.size() > 0) begin
      e = sb2.pop_front();
      n_vec++;
      if (got2.size() == 0) begin
        n_bad++;
        $display("FAIL sl_resp id=%0d: got no response, required rdata=%08h err=%b", e.id, e.rdata, e.err);
      end else begin
        g = got2.pop_front();
        if (g.rdata !== e.rdata || g.err !== e.err || g.cyc - e.cyc != 2 || (prev >= 0 && g.cyc - prev != 2)) begin
          n_bad++;
          $display("FAIL sl_resp id=%0d: got rdata=%08h err=%b lat=%0d gap=%0d, required rdata=%08h err=%b lat=2 gap=2",
                   e.id, g.rdata, g.err, g.cyc - e.cyc, g.cyc - prev, e.rdata, e.err);
        end else begin
          $display("txn %0d: rdata=%08h err=%b lat=%0d", e.id, g.rdata, g.err, g.cyc - e.cyc);
        end
        prev = g.cyc;
      end
    end
    n_vec++;
    if (got2.size() != 0) begin
      n_bad++;
      $display("FAIL sl_extra: got %0d unexpected responses, required 0", got2.size());
      got2.delete();
    end
  endtask

  task automatic test_errors();
    exp_t e;
    exp_t g;
    issue(2, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
    issue(2, 1'b1, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    issue(2, 1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b1);
    issue(2, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
    issue(2, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000FFFF, 32'h0, 1'b1);
    issue(2, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    issue(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h5AADBEEF, 1'b0);
    wait_drain(2);
    while (sb2.size() > 0) begin
      e = sb2.pop_front();
      n_vec++;
      if (got2.size() == 0) begin
        n_bad++;
        $display("FAIL err_resp id=%0d: got no response, required rdata=%08h err=%b", e.id, e.rdata, e.err);
      end else begin
        g = got2.pop_front();
        if (g.rdata !== e.rdata || g.err !== e.err || g.cyc - e.cyc != 2) begin
          n_bad++;
          $display("FAIL err_resp id=%0d: got rdata=%08h err=%b lat=%0d, required rdata=%08h err=%b lat=2",
                   e.id, g.rdata, g.err, g.cyc - e.cyc, e.rdata, e.err);
        end else begin
          $display("txn %0d: rdata=%08h err=%b lat=%0d", e.id, g.rdata, g.err, g.cyc - e.cyc);
        end
      end
    end
    n_vec++;
    if (got2.size() != 0) begin
      n_bad++;
      $display("FAIL err_extra: got %0d unexpected responses, required 0", got2.size());
      got2.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t g;
    int   prev_g = -1;
    int   prev_e = -1;
    issue(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 32'h0, 1'b0);
    issue(1, 1'b1, 2'b10, 1'b0, 32'h44, 32'h55667788, 32'h0, 1'b0);
    issue(1, 1'b1, 2'b00, 1'b0, 32'h41, 32'h00000080, 32'h0, 1'b0);
    issue(1, 1'b1, 2'b01, 1'b0, 32'h46, 32'h00008001, 32'h0, 1'b0);
    issue(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h11228044, 1'b0);
    issue(1, 1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 32'hFFFFFF80, 1'b0);
    issue(1, 1'b0, 2'b01, 1'b0, 32'h46, 32'h0, 32'h00008001, 1'b0);
    issue(1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h80017788, 1'b0);
    wait_drain(1);
    while (sb1.size() > 0) begin
      e = sb1.pop_front();
      n_vec++;
      if (got1.size() == 0) begin
        n_bad++;
        $display("FAIL b2b_resp id=%0d: got no response, required rdata=%08h err=%b", e.id, e.rdata, e.err);
      end else begin
        g = got1.pop_front();
        if (g.rdata !== e.rdata || g.err !== e.err || g.cyc - e.cyc != 1 ||
            (prev_g >= 0 && (g.cyc - prev_g != 1 || e.cyc - prev_e != 1))) begin
          n_bad++;
          $display("FAIL b2b_resp id=%0d: got rdata=%08h err=%b lat=%0d resp_gap=%0d acc_gap=%0d, required rdata=%08h err=%b lat=1 gaps=1",
                   e.id, g.rdata, g.err, g.cyc - e.cyc, g.cyc - prev_g, e.cyc - prev_e, e.rdata, e.err);
        end else begin
          $display("txn %0d: rdata=%08h err=%b lat=%0d", e.id, g.rdata, g.err, g.cyc - e.cyc);
        end
        prev_g = g.cyc;
        prev_e = e.cyc;
      end
    end
    n_vec++;
    if (got1.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_extra: got %0d unexpected responses, required 0", got1.size());
      got1.delete();
    end
  endtask

  task automatic test_reset_mid_access();
    exp_t e;
    exp_t g;
    issue(2, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11112222, 32'h0, 1'b0);
    wait_drain(2);
    sb2.delete();
    got2.delete();
    issue(2, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0);
    e = sb2.pop_back();
    n_vec++;
    if (busy2 !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_busy: got busy=%b before reset, required 1", busy2);
    end
    @(negedge clk);
    rst = 1'b1;
    v2 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rv2 !== 1'b0 || rd2 !== 32'h0 || err2 !== 1'b0 || busy2 !== 1'b0 || rdy2 !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_out: got v=%b rd=%08h err=%b busy=%b rdy=%b, required 0 0 0 0 0", rv2, rd2, err2, busy2, rdy2);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (got2.size() != 0) begin
      n_bad++;
      $display("FAIL abort_resp: got %0d responses after abort, required 0", got2.size());
      got2.delete();
    end
    issue(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0);
    wait_drain(2);
    e = sb2.pop_front();
    n_vec++;
    if (got2.size() == 0) begin
      n_bad++;
      $display("FAIL abort_load id=%0d: got no response, required rdata=%08h", e.id, e.rdata);
    end else begin
      g = got2.pop_front();
      if (g.rdata !== e.rdata || g.err !== 1'b0 || g.cyc - e.cyc != 2) begin
        n_bad++;
        $display("FAIL abort_load id=%0d: got rdata=%08h err=%b lat=%0d, required rdata=%08h err=0 lat=2",
                 e.id, g.rdata, g.err, g.cyc - e.cyc, e.rdata);
      end else begin
        $display("txn %0d: rdata=%08h err=%b lat=%0d", e.id, g.rdata, g.err, g.cyc - e.cyc);
      end
    end
    sb2.delete();
    got2.delete();
  endtask

  task automatic test_alias();
    exp_t e;
    exp_t g;
    issue(2, 1'b1, 2'b10, 1'b0, 32'h00001004, 32'hCAFEF00D, 32'h0, 1'b0);
    issue(2, 1'b0, 2'b10, 1'b0, 32'h00000004, 32'h0, 32'hCAFEF00D, 1'b0);
    issue(2, 1'b0, 2'b10, 1'b0, 32'hFFFFF004, 32'h0, 32'hCAFEF00D, 1'b0);
    wait_drain(2);
    while (sb2.size() > 0) begin
      e = sb2.pop_front();
      n_vec++;
      if (got2.size() == 0) begin
        n_bad++;
        $display("FAIL alias_resp id=%0d: got no response, required rdata=%08h", e.id, e.rdata);
      end else begin
        g = got2.pop_front();
        if (g.rdata !== e.rdata || g.err !== e.err || g.cyc - e.cyc != 2) begin
          n_bad++;
          $display("FAIL alias_resp id=%0d: got rdata=%08h err=%b lat=%0d, required rdata=%08h err=%b lat=2",
                   e.id, g.rdata, g.err, g.cyc - e.cyc, e.rdata, e.err);
        end else begin
          $display("txn %0d: rdata=%08h err=%b lat=%0d", e.id, g.rdata, g.err, g.cyc - e.cyc);
        end
      end
    end
    n_vec++;
    if (got2.size() != 0) begin
      n_bad++;
      $display("FAIL alias_extra: got %0d unexpected responses, required 0", got2.size());
      got2.delete();
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_reset_mid_access();
    test_alias();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
